// File: rtl/rgb_pwm_driver.sv
// Three-channel PWM driver for a discrete RGB LED. Duties are latched at
// period wraps so a colour change never truncates a pulse in flight.
module rgb_pwm_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] duty,
  output logic       led
);
  // 0xFF is forced full-on; otherwise the last count (255) would read low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= 1'b0;
    else     led <= enable && ((duty == 8'hFF) || (pwm_cnt < duty));
  end
endmodule

module rgb_pwm_driver #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] light,
  input  logic        enable,
  output logic        led_r,
  output logic        led_g,
  output logic        led_b,
  output logic        period_start
);
  localparam int NUM_LANES = 3;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]                pre;
  logic [7:0]                   pwm_cnt;
  logic [NUM_LANES-1:0][7:0]    duty;
  logic [NUM_LANES-1:0]         led;
  logic                         tick;
  logic                         wrap;

  assign tick = enable && (pre == PRE_MAX);
  assign wrap = tick && (pwm_cnt == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre          <= '0;
      pwm_cnt      <= '0;
      duty         <= '0;
      period_start <= 1'b0;
    end else if (!enable) begin
      // idle: counters parked at 0, duties follow light so restart uses fresh colour
      pre          <= '0;
      pwm_cnt      <= '0;
      duty         <= light;
      period_start <= 1'b0;
    end else begin
      pre          <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
      if (wrap) duty    <= light;
      period_start <= wrap;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    rgb_pwm_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable),
      .pwm_cnt (pwm_cnt),
      .duty    (duty[i]),
      .led     (led[i])
    );
  end

  assign led_r = led[2];
  assign led_g = led[1];
  assign led_b = led[0];
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Bench for rgb_pwm_driver: a PRESCALE=1 and a PRESCALE=4 instance share stimulus;
// per-period expected pulse widths are queued when stimulus is applied.
module tb_rgb_pwm_driver;
  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [23:0] light;
  logic        r1, g1, b1, ps1;
  logic        r4, g4, b4, ps4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int r, g, b, len, rises;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  rgb_pwm_driver #(.PRESCALE(1)) u_d1 (
    .clk(clk), .rst(rst), .light(light), .enable(enable),
    .led_r(r1), .led_g(g1), .led_b(b1), .period_start(ps1)
  );

  rgb_pwm_driver #(.PRESCALE(4)) u_d4 (
    .clk(clk), .rst(rst), .light(light), .enable(enable),
    .led_r(r4), .led_g(g4), .led_b(b4), .period_start(ps4)
  );

  // Collects one period: high counts per channel, length, and rising edges.
  // Unless from_now, waits for a period_start (checking the current sample first).
  task automatic measure(input bit sel4, input bit from_now, input int chg_at,
                         input logic [23:0] chg_val,
                         output int r, output int g, output int b,
                         output int len, output int rises, output bit to);
    logic [2:0] prev, cur;
    int guard;
    r = 0; g = 0; b = 0; len = 0; rises = 0; to = 1'b0; guard = 0;
    if (!from_now) begin
      while (!(sel4 ? ps4 : ps1)) begin
        @(negedge clk);
        guard++;
        if (guard > 2100) begin to = 1'b1; return; end
      end
    end
    prev = sel4 ? {r4, g4, b4} : {r1, g1, b1};
    do begin
      @(negedge clk);
      len++;
      if (len == chg_at) light = chg_val;
      cur = sel4 ? {r4, g4, b4} : {r1, g1, b1};
      r += int'(cur[2]);
      g += int'(cur[1]);
      b += int'(cur[0]);
      rises += $countones(cur & ~prev);
      prev = cur;
      if (len > 1100) begin to = 1'b1; return; end
    end while (!(sel4 ? ps4 : ps1));
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; light = 24'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({r1, g1, b1} !== 3'b000) begin
      errors++; $display("FAIL reset_leds_p1 got=%b exp=000", {r1, g1, b1});
    end
    checks++;
    if (ps1 !== 1'b0) begin errors++; $display("FAIL reset_ps_p1 got=%b exp=0", ps1); end
    checks++;
    if ({r4, g4, b4} !== 3'b000) begin
      errors++; $display("FAIL reset_leds_p4 got=%b exp=000", {r4, g4, b4});
    end
    checks++;
    if (u_d1.pwm_cnt !== 8'd0 || u_d1.duty !== 24'h0) begin
      errors++; $display("FAIL reset_state cnt=%0d duty=%h exp cnt=0 duty=000000", u_d1.pwm_cnt, u_d1.duty);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_duty_map();
    int r, g, b, len, rises;
    bit to;
    exp_t e;
    light = 24'h00_80_FF;
    @(negedge clk);
    enable = 1'b1;
    exp_q.push_back('{0, 128, 256, 256, 1});
    exp_q.push_back('{0, 128, 256, 256, 1});
    for (int p = 0; p < 2; p++) begin
      measure(1'b0, 1'b0, 0, 24'h0, r, g, b, len, rises, to);
      e = exp_q.pop_front();
      checks++;
      if (to || r != e.r || g != e.g || b != e.b || len != e.len || rises != e.rises) begin
        errors++;
        $display("FAIL duty_map[%0d] got r/g/b=%0d/%0d/%0d len=%0d rises=%0d to=%0b exp %0d/%0d/%0d len=%0d rises=%0d",
                 p, r, g, b, len, rises, to, e.r, e.g, e.b, e.len, e.rises);
      end
    end
  endtask

  task automatic test_prescale();
    int r, g, b, len, rises;
    bit to;
    exp_t e;
    light = 24'h01_00_00;
    @(negedge clk);
    exp_q.push_back('{4, 0, 0, 1024, 1});
    measure(1'b1, 1'b0, 0, 24'h0, r, g, b, len, rises, to);
    e = exp_q.pop_front();
    checks++;
    if (to || r != e.r || g != e.g || b != e.b || len != e.len || rises != e.rises) begin
      errors++;
      $display("FAIL prescale4 got r/g/b=%0d/%0d/%0d len=%0d rises=%0d to=%0b exp %0d/%0d/%0d len=%0d rises=%0d",
               r, g, b, len, rises, to, e.r, e.g, e.b, e.len, e.rises);
    end
  endtask

  task automatic test_mid_change();
    int r, g, b, len, rises;
    bit to;
    exp_t e;
    light = 24'h40_40_40;
    @(negedge clk);
    exp_q.push_back('{64, 64, 64, 256, 3});
    exp_q.push_back('{192, 192, 192, 256, 3});
    for (int p = 0; p < 2; p++) begin
      measure(1'b0, 1'b0, (p == 0) ? 100 : 0, 24'hC0_C0_C0, r, g, b, len, rises, to);
      e = exp_q.pop_front();
      checks++;
      if (to || r != e.r || g != e.g || b != e.b || len != e.len || rises != e.rises) begin
        errors++;
        $display("FAIL mid_change[%0d] got r/g/b=%0d/%0d/%0d len=%0d rises=%0d to=%0b exp %0d/%0d/%0d len=%0d rises=%0d",
                 p, r, g, b, len, rises, to, e.r, e.g, e.b, e.len, e.rises);
      end
    end
  endtask

  task automatic test_async_reset();
    int r, g, b, len, rises;
    bit to;
    exp_t e;
    repeat (30) @(negedge clk);
    checks++;
    if (u_d1.pwm_cnt !== 8'd30 || {r1, g1, b1} !== 3'b111) begin
      errors++; $display("FAIL pre_reset got cnt=%0d leds=%b exp cnt=30 leds=111", u_d1.pwm_cnt, {r1, g1, b1});
    end
    light = 24'hFF_FF_FF;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({r1, g1, b1, ps1, r4, g4, b4, ps4} !== 8'h00 || u_d1.pwm_cnt !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got outs=%b cnt=%0d exp outs=00000000 cnt=0",
               {r1, g1, b1, ps1, r4, g4, b4, ps4}, u_d1.pwm_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back('{0, 0, 0, 256, 0});
    exp_q.push_back('{256, 256, 256, 256, 3});
    for (int p = 0; p < 2; p++) begin
      measure(1'b0, (p == 0), 0, 24'h0, r, g, b, len, rises, to);
      e = exp_q.pop_front();
      checks++;
      if (to || r != e.r || g != e.g || b != e.b || len != e.len || rises != e.rises) begin
        errors++;
        $display("FAIL post_reset[%0d] got r/g/b=%0d/%0d/%0d len=%0d rises=%0d to=%0b exp %0d/%0d/%0d len=%0d rises=%0d",
                 p, r, g, b, len, rises, to, e.r, e.g, e.b, e.len, e.rises);
      end
    end
  endtask

  task automatic test_enable_restart();
    int r, g, b, len, rises;
    bit to;
    exp_t e;
    repeat (50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if ({r1, g1, b1, ps1} !== 4'b0000 || u_d1.pwm_cnt !== 8'd0 || u_d4.pre !== 2'd0) begin
      errors++;
      $display("FAIL enable_drop got outs=%b cnt=%0d pre4=%0d exp outs=0000 cnt=0 pre4=0",
               {r1, g1, b1, ps1}, u_d1.pwm_cnt, u_d4.pre);
    end
    light = 24'h10_20_30;
    @(negedge clk);
    enable = 1'b1;
    exp_q.push_back('{16, 32, 48, 256, 3});
    measure(1'b0, 1'b1, 0, 24'h0, r, g, b, len, rises, to);
    e = exp_q.pop_front();
    checks++;
    if (to || r != e.r || g != e.g || b != e.b || len != e.len || rises != e.rises) begin
      errors++;
      $display("FAIL restart got r/g/b=%0d/%0d/%0d len=%0d rises=%0d to=%0b exp %0d/%0d/%0d len=%0d rises=%0d",
               r, g, b, len, rises, to, e.r, e.g, e.b, e.len, e.rises);
    end
  endtask

  task automatic test_enable_at_wrap();
    repeat (255) @(negedge clk);
    checks++;
    if (u_d1.pwm_cnt !== 8'd255) begin
      errors++; $display("FAIL wrap_setup got cnt=%0d exp cnt=255", u_d1.pwm_cnt);
    end
    light  = 24'hAB_CD_EF;
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (ps1 !== 1'b0 || u_d1.pwm_cnt !== 8'd0 || u_d1.pre !== 1'b0 || u_d1.duty !== 24'hAB_CD_EF) begin
      errors++;
      $display("FAIL enable_at_wrap got ps=%b cnt=%0d pre=%0d duty=%h exp ps=0 cnt=0 pre=0 duty=abcdef",
               ps1, u_d1.pwm_cnt, u_d1.pre, u_d1.duty);
    end
    light = 24'h12_34_56;
    @(negedge clk);
    checks++;
    if (u_d1.duty !== 24'h12_34_56 || {r1, g1, b1, ps1} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_track got duty=%h outs=%b exp duty=123456 outs=0000", u_d1.duty, {r1, g1, b1, ps1});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_duty_map();
    test_prescale();
    test_mid_change();
    test_async_reset();
    test_enable_restart();
    test_enable_at_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rgb_pwm_driver.md
Name: rgb_pwm_driver

Overview:
Downstream stage of the lights selector. Consumes the 24-bit selected colour (R = light[23:16], G = [15:8], B = [7:0]) and drives three PWM pins for a discrete RGB LED. Each channel's duty cycle is proportional to its 8-bit code. Duty values are latched only at PWM period boundaries, so colour changes never produce a truncated or glitched pulse.

Parameters:
PRESCALE, 4, clock cycles per PWM count step; legal values are ≥1; PWM period = 256*PRESCALE clocks

Ports:
clk           input   1   system clock, rising edge
rst           input   1   asynchronous, active-high reset
light         input   24  colour code from selector, {R,G,B}
enable        input   1   1 = PWM running, 0 = LEDs off
led_r         output  1   red PWM output, registered
led_g         output  1   green PWM output, registered
led_b         output  1   blue PWM output, registered
period_start  output  1   one-cycle pulse marking the start of each PWM period

Behaviour:
- Single clock domain (clk). rst is asynchronous and active-high.
- Reset values: prescaler = 0, pwm_cnt = 0, duty_r/g/b = 0; led_r, led_g, led_b and period_start = 0. Reset takes effect immediately, including mid-period.
- Prescaler: counts 0..PRESCALE-1 and wraps. tick = enable && (pre == PRESCALE-1). With PRESCALE = 1, tick is asserted on every enabled cycle.
- pwm_cnt: 8-bit counter, increments on tick, wraps 255 -> 0.
- Wrap event: tick && pwm_cnt == 255. At the wrap event:
  - duty_r/g/b <= light[23:16] / light[15:8] / light[7:0];
  - period_start <= 1 for exactly one cycle; it is 0 otherwise.
- light changing mid-period has no effect until the next wrap event. Only the light value sampled at the wrap edge is used.
- Output compare (registered, 1-cycle latency from pwm_cnt), per channel:
  - led_x <= enable && ((duty_x == 8'hFF) || (pwm_cnt < duty_x)).
  - duty 0x00: output never high.
  - duty 0xFF: output constantly high (special case, full on).
  - duty N otherwise (1..254): output high for N*PRESCALE clocks per period, starting at period start.
- enable = 0:
  - prescaler and pwm_cnt are held at 0 synchronously;
  - led_* go to 0 on the next edge; period_start = 0;
  - duty_* track light every cycle (transparent load).
- enable 0 -> 1: the first period begins immediately at pwm_cnt = 0 using the duties loaded during the previous cycle. No period_start pulse is generated for this first period; pulses begin at the first wrap event.
- Simultaneous enable fall and wrap event: enable wins. Counters clear, no period_start pulse, duties load from light.
- No combinational path from any input to any output.

Test Plan:
1. PRESCALE=1, enable=1, light=24'h00_80_FF held. Over one full 256-cycle period after a period_start pulse: led_r high 0 cycles, led_g high 128 contiguous cycles, led_b high all 256 cycles. period_start recurs exactly every 256 cycles.
2. PRESCALE=4, light=24'h01_00_00. Per period: led_r high exactly 4 clocks. period_start spacing is 1024 clocks.
3. PRESCALE=1. light changes from 24'h40_40_40 to 24'h C0_C0_C0 at pwm_cnt=100. Current period: each LED high 64 cycles. Next period: each LED high 192 cycles. No partial pulse is observed.
4. Assert rst asynchronously (off-edge) at pwm_cnt=30 while all LEDs are high. All outputs go to 0 immediately. After release with light=24'hFF_FF_FF, the first period has all LEDs constantly low (duty = 0 from reset); from the second period onward all LEDs are constantly high.
5. enable dropped mid-period. On the next edge all LEDs = 0 and pwm_cnt = 0. Then set light=24'h10_20_30 and enable=1. With PRESCALE=1, the first period gives R/G/B high 16/32/48 cycles with no preceding period_start pulse; the next pulse comes 256 cycles after enable rises.
6. PRESCALE=1, enable deasserted in exactly the wrap-event cycle. No period_start pulse occurs, counters read 0, and duty_* equal the current light value.
